// File: rtl/button_event_gen_pkg.sv
// Shared types and defaults for the button event generator.
// FSM state encoding, default hold/repeat tick counts and a small max() helper.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2,
        REPEAT  = 2'd3
    } btn_state_t;

    localparam int BTN_LONG_TICKS_DEF   = 100;
    localparam int BTN_REPEAT_TICKS_DEF = 20;

    function automatic int btn_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_event_gen_if.sv
// Button level in, one-cycle UI events and the held level out.
// The slave side is the event generator; the master side is whoever drives btn and consumes events.
interface button_event_gen_if;
    logic btn;
    logic press_p;
    logic release_p;
    logic long_p;
    logic rpt_p;
    logic held;

    modport master (
        output btn,
        input  press_p,
        input  release_p,
        input  long_p,
        input  rpt_p,
        input  held
    );

    modport slave (
        input  btn,
        output press_p,
        output release_p,
        output long_p,
        output rpt_p,
        output held
    );
endinterface

// File: rtl/button_event_gen_tick_counter.sv
// Clearable up-counter with enable; tc flags when the count equals the supplied terminal value.
// Callers clear it on every terminal count, so it never needs to wrap.
module btn_tick_counter #(
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] tc_val,
    output logic             tc
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tc = (cnt == tc_val);

endmodule

// File: rtl/button_event_gen.sv
// Turns a debounced button level into press / release / long-press / auto-repeat pulses.
// Auto-repeat (REPEAT state, rpt_p) is built only when BTN_AUTOREPEAT_EN is defined.
//
// state   | meaning
// --------+----------------------------------------------
// IDLE    | button up, waiting for a rising edge
// PRESSED | held, counting toward LONG_TICKS
// LONG    | long_p fired; counting toward first repeat
// REPEAT  | auto-repeating every REPEAT_TICKS
module button_event_gen
    import btn_pkg::*;
#(
    parameter int LONG_TICKS   = BTN_LONG_TICKS_DEF,
    parameter int REPEAT_TICKS = BTN_REPEAT_TICKS_DEF
) (
    input  logic               clk,
    input  logic               rst,
    button_event_gen_if.slave  bus
);

    localparam int               CNT_W   = $clog2(btn_max(LONG_TICKS, REPEAT_TICKS));
    localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_TICKS - 1);
`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_TICKS - 1);
`endif

    btn_state_t       state_q, state_d;
    logic             btn_q;
    logic             rise, fall;
    logic             cnt_clr, cnt_en, tc;
    logic [CNT_W-1:0] tc_val;
    logic             press_d, release_d, long_d, held_d;
    logic             press_q, release_q, long_q, held_q;
`ifdef BTN_AUTOREPEAT_EN
    logic             rpt_d, rpt_q;
`endif

    assign rise = bus.btn & ~btn_q;
    assign fall = ~bus.btn & btn_q;

`ifdef BTN_AUTOREPEAT_EN
    assign tc_val = (state_q == PRESSED) ? LONG_TC : REPEAT_TC;
`else
    assign tc_val = LONG_TC;
`endif

    btn_tick_counter #(.CNT_W(CNT_W)) u_tick_counter (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .tc_val (tc_val),
        .tc     (tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            btn_q     <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            held_q    <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            rpt_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            btn_q     <= bus.btn;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            held_q    <= held_d;
`ifdef BTN_AUTOREPEAT_EN
            rpt_q     <= rpt_d;
`endif
        end
    end

    // Release is tested first everywhere so a fall on a terminal count wins.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rise) state_d = PRESSED;
            PRESSED: begin
                if (fall)                 state_d = IDLE;
                else if (bus.btn && tc)   state_d = LONG;
            end
            LONG: begin
                if (fall)                 state_d = IDLE;
`ifdef BTN_AUTOREPEAT_EN
                else if (bus.btn && tc)   state_d = REPEAT;
`endif
            end
`ifdef BTN_AUTOREPEAT_EN
            REPEAT:  if (fall) state_d = IDLE;
`endif
            default:                      state_d = IDLE;
        endcase
    end

    always_comb begin
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        rpt_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (rise) begin
                    press_d = 1'b1;
                    cnt_clr = 1'b1;
                end
            end
            PRESSED: begin
                if (fall) begin
                    release_d = 1'b1;
                    cnt_clr   = 1'b1;
                end else if (bus.btn && tc) begin
                    long_d  = 1'b1;
                    cnt_clr = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
            end
`ifdef BTN_AUTOREPEAT_EN
            LONG, REPEAT: begin
                if (fall) begin
                    release_d = 1'b1;
                    cnt_clr   = 1'b1;
                end else if (bus.btn && tc) begin
                    rpt_d   = 1'b1;
                    cnt_clr = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
            end
`else
            // Without auto-repeat the counter stays frozen until release.
            LONG: begin
                if (fall) begin
                    release_d = 1'b1;
                    cnt_clr   = 1'b1;
                end
            end
`endif
            default: cnt_clr = 1'b1;
        endcase
        held_d = (state_d != IDLE);
    end

    assign bus.press_p   = press_q;
    assign bus.release_p = release_q;
    assign bus.long_p    = long_q;
    assign bus.held      = held_q;
`ifdef BTN_AUTOREPEAT_EN
    assign bus.rpt_p     = rpt_q;
`else
    assign bus.rpt_p     = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_gen.sv
// Scoreboard bench for button_event_gen with LONG_TICKS=100, REPEAT_TICKS=20.
// Stimulus pushes expected (cycle, event) pairs; a negedge monitor pops them as pulses appear.
module tb_button_event_gen;

    logic clk = 1'b0;
    logic rst;

    button_event_gen_if bus ();

    button_event_gen #(
        .LONG_TICKS   (100),
        .REPEAT_TICKS (20)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam int EV_PRESS   = 0;
    localparam int EV_RELEASE = 1;
    localparam int EV_LONG    = 2;
    localparam int EV_RPT     = 3;

`ifdef BTN_AUTOREPEAT_EN
    localparam int RPT_N = 3;
`else
    localparam int RPT_N = 0;
`endif

    typedef struct {
        int at;
        int kind;
    } ev_t;

    ev_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    int  p0;

    logic [4:0] outs;
    assign outs = {bus.held, bus.rpt_p, bus.long_p, bus.release_p, bus.press_p};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cyc %0d: got %0h required %0h", name, cyc, act, req);
        end
    endtask

    task automatic push_ev(input int at, input int kind);
        ev_t e;
        e.at   = at;
        e.kind = kind;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        logic [3:0] pv;
        ev_t        e;
        int         k;
        pv = {bus.rpt_p, bus.long_p, bus.release_p, bus.press_p};
        if (pv != 4'b0000) begin
            checks++;
            k = pv[0] ? EV_PRESS : pv[1] ? EV_RELEASE : pv[2] ? EV_LONG : EV_RPT;
            if ($countones(pv) != 1) begin
                errors++;
                $display("FAIL exclusive at cyc %0d: pulses %b required one-hot", cyc, pv);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected event kind %0d at cyc %0d: required none", k, cyc);
            end else begin
                e = exp_q.pop_front();
                if (e.at != cyc || e.kind != k) begin
                    errors++;
                    $display("FAIL event: got kind %0d at cyc %0d required kind %0d at cyc %0d",
                             k, cyc, e.kind, e.at);
                end
            end
        end
    end

    // Hold btn for n sampled edges; event times are given relative to the press cycle.
    task automatic run_hold(input int n, input int long_at, input int rpts);
        int p;
        @(negedge clk);
        bus.btn = 1'b1;
        p = cyc + 1;
        push_ev(p, EV_PRESS);
        if (long_at > 0) push_ev(p + long_at, EV_LONG);
        for (int i = 0; i < rpts; i++) push_ev(p + long_at + 20 * (i + 1), EV_RPT);
        push_ev(p + n, EV_RELEASE);
        repeat (n) @(negedge clk);
        chk("held_during", {31'b0, bus.held}, 32'd1);
        bus.btn = 1'b0;
        @(negedge clk);
        chk("held_after", {31'b0, bus.held}, 32'd0);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        bus.btn = 1'b0;
        rst     = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outs", {27'b0, outs}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        run_hold(30, 0, 0);          // short press
        run_hold(165, 100, RPT_N);   // long hold, repeats only with auto-repeat
        run_hold(100, 0, 0);         // release lands on cnt==99: no long_p
        run_hold(1, 0, 0);           // single-cycle press

        // Reset mid-hold at press+50 for three cycles, button kept down.
        @(negedge clk);
        bus.btn = 1'b1;
        p0 = cyc + 1;
        push_ev(p0, EV_PRESS);
        repeat (50) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("outs_in_reset", {27'b0, outs}, 32'd0);
        end
        rst = 1'b0;
        push_ev(p0 + 53, EV_PRESS);
        push_ev(p0 + 153, EV_LONG);
        push_ev(p0 + 161, EV_RELEASE);
        repeat (108) @(negedge clk);
        chk("held_before_rel", {31'b0, bus.held}, 32'd1);
        bus.btn = 1'b0;
        @(negedge clk);
        chk("held_after_rel", {31'b0, bus.held}, 32'd0);
        repeat (10) @(negedge clk);

        chk("events_pending", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
